// File: rtl/key_event_if.sv
// Event port between the key event sequencer and its consumer.
// The producer drives valid/key/type/drop; the consumer drives ready.
`timescale 1ns/1ps
interface key_event_if #(
  parameter int KEY_W = 2
);
  logic             evt_valid;
  logic             evt_ready;
  logic [KEY_W-1:0] evt_key;
  logic [1:0]       evt_type;
  logic             evt_drop;

  modport master (
    output evt_valid, evt_key, evt_type, evt_drop,
    input  evt_ready
  );

  modport slave (
    input  evt_valid, evt_key, evt_type, evt_drop,
    output evt_ready
  );
endinterface

// File: rtl/key_event_ctrl.sv
// Classifies debounced key lines into SHORT/LONG/REPEAT/LONG_RELEASE events and
// serialises them through a round-robin arbiter onto one valid/ready port.
`timescale 1ns/1ps
module key_event_ctrl #(
  parameter int NUM_KEYS   = 4,
  parameter int KEY_W      = 2,
  parameter int CNT_W      = 27,
  parameter int LONG_CNT   = 100_000_000,
  parameter int REPEAT_CNT = 10_000_000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic [NUM_KEYS-1:0] key_state,
  key_event_if.master         ev
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    HELD      = 2'd1,
    LONG_HELD = 2'd2
  } kstate_t;

  localparam logic [1:0] T_SHORT  = 2'b00;
  localparam logic [1:0] T_LONG   = 2'b01;
  localparam logic [1:0] T_REPEAT = 2'b10;
  localparam logic [1:0] T_LREL   = 2'b11;

  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CNT - 1);
  localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CNT - 1);
  localparam logic [KEY_W-1:0] KEY_LAST  = KEY_W'(NUM_KEYS - 1);

  logic [NUM_KEYS-1:0] key_prev;
  logic                armed;
  logic [NUM_KEYS-1:0] press;
  logic [NUM_KEYS-1:0] rel;

  kstate_t             st_q  [NUM_KEYS];
  kstate_t             st_d  [NUM_KEYS];
  logic [CNT_W-1:0]    hc_q  [NUM_KEYS];
  logic [CNT_W-1:0]    hc_d  [NUM_KEYS];
  logic [NUM_KEYS-1:0] fire;
  logic [1:0]          fire_type [NUM_KEYS];

  logic [NUM_KEYS-1:0] pend_q;
  logic [NUM_KEYS-1:0] pend_d;
  logic [1:0]          ptype_q [NUM_KEYS];
  logic [1:0]          ptype_d [NUM_KEYS];
  logic [NUM_KEYS-1:0] gnt;
  logic [NUM_KEYS-1:0] drop;

  logic [KEY_W-1:0]    rr_q;
  logic [KEY_W-1:0]    win;
  logic [KEY_W-1:0]    cand;
  logic                found;
  logic                load;

  logic                valid_q;
  logic [KEY_W-1:0]    key_q;
  logic [1:0]          type_q;
  logic                drop_q;

  // Edges are ignored on the first clock after reset so a key held through
  // reset is not mistaken for a fresh press.
  assign press = {NUM_KEYS{armed}} & key_prev & ~key_state;
  assign rel   = {NUM_KEYS{armed}} & ~key_prev & key_state;

  always_comb begin
    for (int i = 0; i < NUM_KEYS; i++) begin
      st_d[i]      = st_q[i];
      hc_d[i]      = hc_q[i];
      fire[i]      = 1'b0;
      fire_type[i] = T_SHORT;
      if (!en) begin
        st_d[i] = IDLE;
        hc_d[i] = '0;
      end else begin
        case (st_q[i])
          IDLE: begin
            if (press[i]) begin
              st_d[i] = HELD;
              hc_d[i] = '0;
            end
          end
          HELD: begin
            if (rel[i]) begin
              fire[i] = 1'b1;
              st_d[i] = IDLE;
              hc_d[i] = '0;
            end else if (hc_q[i] == LONG_LAST) begin
              fire[i]      = 1'b1;
              fire_type[i] = T_LONG;
              st_d[i]      = LONG_HELD;
              hc_d[i]      = '0;
            end else begin
              hc_d[i] = hc_q[i] + CNT_W'(1);
            end
          end
          LONG_HELD: begin
            if (rel[i]) begin
              fire[i]      = 1'b1;
              fire_type[i] = T_LREL;
              st_d[i]      = IDLE;
              hc_d[i]      = '0;
            end else if (hc_q[i] == REP_LAST) begin
              fire[i]      = 1'b1;
              fire_type[i] = T_REPEAT;
              hc_d[i]      = '0;
            end else begin
              hc_d[i] = hc_q[i] + CNT_W'(1);
            end
          end
          default: begin
            st_d[i] = IDLE;
            hc_d[i] = '0;
          end
        endcase
      end
    end
  end

  // Round-robin: first pending slot at or after the pointer, wrapping.
  always_comb begin
    win   = '0;
    cand  = '0;
    found = 1'b0;
    for (int j = 0; j < NUM_KEYS; j++) begin
      if (int'(rr_q) + j >= NUM_KEYS) cand = KEY_W'(int'(rr_q) + j - NUM_KEYS);
      else                            cand = KEY_W'(int'(rr_q) + j);
      if (!found && pend_q[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
    load = en & (~valid_q | ev.evt_ready) & found;
    gnt  = '0;
    if (load) gnt[win] = 1'b1;
  end

  // A slot being granted this cycle can take a new event; a full, ungranted slot drops it.
  always_comb begin
    for (int i = 0; i < NUM_KEYS; i++) begin
      pend_d[i]  = pend_q[i];
      ptype_d[i] = ptype_q[i];
      drop[i]    = 1'b0;
      if (!en) begin
        pend_d[i] = 1'b0;
      end else if (fire[i]) begin
        if (!pend_q[i] || gnt[i]) begin
          pend_d[i]  = 1'b1;
          ptype_d[i] = fire_type[i];
        end else begin
          drop[i] = 1'b1;
        end
      end else if (gnt[i]) begin
        pend_d[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_prev <= '1;
      armed    <= 1'b0;
      pend_q   <= '0;
      rr_q     <= '0;
      valid_q  <= 1'b0;
      key_q    <= '0;
      type_q   <= T_SHORT;
      drop_q   <= 1'b0;
      for (int i = 0; i < NUM_KEYS; i++) begin
        st_q[i]    <= IDLE;
        hc_q[i]    <= '0;
        ptype_q[i] <= T_SHORT;
      end
    end else begin
      key_prev <= key_state;
      armed    <= 1'b1;
      pend_q   <= pend_d;
      st_q     <= st_d;
      hc_q     <= hc_d;
      ptype_q  <= ptype_d;
      drop_q   <= |drop;
      if (load) begin
        valid_q <= 1'b1;
        key_q   <= win;
        type_q  <= ptype_q[win];
        rr_q    <= (win == KEY_LAST) ? '0 : win + KEY_W'(1);
      end else if (ev.evt_ready) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign ev.evt_valid = valid_q;
  assign ev.evt_key   = key_q;
  assign ev.evt_type  = type_q;
  assign ev.evt_drop  = drop_q;

endmodule

// File: tb/tb_key_event_ctrl.sv
// Bench for key_event_ctrl: vector table, corner-case sequences and random
// stimulus against a timestamp-based reference model.
`timescale 1ns/1ps
module tb_key_event_ctrl;

  localparam int NK = 4;
  localparam int LC = 10;
  localparam int RC = 4;

  logic          clk;
  logic          rst_n;
  logic          en;
  logic [NK-1:0] key_state;

  key_event_if #(.KEY_W(2)) ev ();

  key_event_ctrl #(
    .NUM_KEYS(NK), .KEY_W(2), .CNT_W(8), .LONG_CNT(LC), .REPEAT_CNT(RC)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .key_state(key_state), .ev(ev)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int nvec;
  int nerr;
  int cyc;
  int ndrop;

  typedef struct { int c; int k; int t; } acc_t;
  acc_t acc_q[$];

  // Reference model: press timestamps instead of counters.
  bit          m_trk [NK];
  int          m_tp  [NK];
  bit [NK-1:0] m_prev;
  bit          m_arm;
  bit          m_pv  [NK];
  bit [1:0]    m_pt  [NK];
  int          m_rr;
  bit          m_valid;
  int          m_key;
  bit [1:0]    m_type;
  bit          m_drop;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", nm, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < NK; k++) begin
      m_trk[k] = 0; m_tp[k] = 0; m_pv[k] = 0; m_pt[k] = 0;
    end
    m_prev = '1; m_arm = 0; m_rr = 0;
    m_valid = 0; m_key = 0; m_type = 0; m_drop = 0;
  endtask

  task automatic model_edge(input bit [NK-1:0] ks, input bit en_i, input bit rdy_i);
    bit       evf [NK];
    bit [1:0] evt [NK];
    bit       any;
    bit       load;
    int       w;
    int       age;
    int       idx;
    any = 0;
    for (int k = 0; k < NK; k++) begin
      evf[k] = 0; evt[k] = 0;
      if (m_pv[k]) any = 1;
      if (en_i && m_arm) begin
        if (m_trk[k]) begin
          age = cyc - m_tp[k];
          if (!m_prev[k] && ks[k]) begin
            evf[k] = 1; evt[k] = (age <= LC) ? 2'd0 : 2'd3; m_trk[k] = 0;
          end else if (age == LC) begin
            evf[k] = 1; evt[k] = 2'd1;
          end else if (age > LC && (age - LC) % RC == 0) begin
            evf[k] = 1; evt[k] = 2'd2;
          end
        end else if (m_prev[k] && !ks[k]) begin
          m_trk[k] = 1; m_tp[k] = cyc;
        end
      end
      if (!en_i) m_trk[k] = 0;
    end
    load = en_i && (!m_valid || rdy_i) && any;
    w = -1;
    if (load) begin
      for (int j = 0; j < NK; j++) begin
        idx = (m_rr + j) % NK;
        if (w < 0 && m_pv[idx]) w = idx;
      end
      m_valid = 1; m_key = w; m_type = m_pt[w]; m_rr = (w + 1) % NK;
    end else if (rdy_i) begin
      m_valid = 0;
    end
    m_drop = 0;
    for (int k = 0; k < NK; k++) begin
      if (!en_i) m_pv[k] = 0;
      else if (evf[k]) begin
        if (!m_pv[k] || w == k) begin m_pv[k] = 1; m_pt[k] = evt[k]; end
        else m_drop = 1;
      end else if (w == k) m_pv[k] = 0;
    end
    m_prev = ks;
    m_arm  = 1;
  endtask

  task automatic step(input logic [NK-1:0] ks, input logic en_i, input logic rdy_i);
    key_state    = ks;
    en           = en_i;
    ev.evt_ready = rdy_i;
    if (ev.evt_valid && rdy_i) acc_q.push_back('{cyc, int'(ev.evt_key), int'(ev.evt_type)});
    @(posedge clk);
    model_edge(ks, en_i, rdy_i);
    cyc++;
    #1;
    if (ev.evt_drop) ndrop++;
  endtask

  task automatic check_model();
    chk("valid", ev.evt_valid, m_valid);
    if (m_valid) begin
      chk("key", ev.evt_key, m_key);
      chk("type", ev.evt_type, m_type);
    end
    chk("drop", ev.evt_drop, m_drop);
  endtask

  task automatic mstep(input logic [NK-1:0] ks, input logic en_i, input logic rdy_i);
    step(ks, en_i, rdy_i);
    check_model();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_valid", ev.evt_valid, 0);
    chk("reset_key", ev.evt_key, 0);
    chk("reset_type", ev.evt_type, 0);
    chk("reset_drop", ev.evt_drop, 0);
    rst_n = 1'b1;
  endtask

  typedef struct {
    bit          rb;
    logic [NK-1:0] ks;
    logic        v;
    logic [1:0]  k;
    logic [1:0]  t;
  } vec_t;
  vec_t tbl[$];

  task automatic add(input bit rb, input logic [NK-1:0] ks, input logic v,
                     input logic [1:0] k, input logic [1:0] t);
    tbl.push_back('{rb, ks, v, k, t});
  endtask

  int exp_off [4] = '{12, 16, 20, 22};
  int exp_typ [4] = '{1, 2, 2, 3};
  int p0;
  logic [NK-1:0] ks_r;
  logic          en_r;

  initial begin
    nvec = 0; nerr = 0; cyc = 0; ndrop = 0;
    rst_n = 1'b0; en = 1'b1; key_state = '1; ev.evt_ready = 1'b1;

    // Short press on key0, then a three-key release served round-robin twice.
    add(0, 4'hF, 0, 0, 0);
    for (int i = 0; i < 5; i++) add(0, 4'hE, 0, 0, 0);
    add(0, 4'hF, 0, 0, 0);
    add(0, 4'hF, 1, 0, 0);
    add(0, 4'hF, 0, 0, 0);
    add(1, 4'hF, 0, 0, 0);
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 3; i++) add(0, 4'h2, 0, 0, 0);
      add(0, 4'hF, 0, 0, 0);
      add(0, 4'hF, 1, 0, 0);
      add(0, 4'hF, 1, 2, 0);
      add(0, 4'hF, 1, 3, 0);
      add(0, 4'hF, 0, 0, 0);
    end

    do_reset();
    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].rb) do_reset();
      step(tbl[i].ks, 1'b1, 1'b1);
      chk("tbl_valid", ev.evt_valid, tbl[i].v);
      if (tbl[i].v) begin
        chk("tbl_key", ev.evt_key, tbl[i].k);
        chk("tbl_type", ev.evt_type, tbl[i].t);
      end
      chk("tbl_drop", ev.evt_drop, 0);
    end

    // key1 held 20 cycles: LONG, two REPEATs, LONG_RELEASE.
    repeat (3) mstep(4'hF, 1, 1);
    acc_q.delete();
    p0 = cyc;
    repeat (20) mstep(4'hD, 1, 1);
    repeat (4) mstep(4'hF, 1, 1);
    chk("t2_count", acc_q.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < acc_q.size()) begin
        chk("t2_offset", acc_q[i].c - p0, exp_off[i]);
        chk("t2_key", acc_q[i].k, 1);
        chk("t2_type", acc_q[i].t, exp_typ[i]);
      end
    end

    // Back-pressure on key2: one on the port, one pending, the third dropped.
    acc_q.delete();
    ndrop = 0;
    for (int r = 0; r < 2; r++) begin
      repeat (2) mstep(4'hB, 1, 0);
      repeat (2) mstep(4'hF, 1, 0);
    end
    repeat (2) mstep(4'hB, 1, 0);
    mstep(4'hF, 1, 0);
    chk("t4_drop_seen", ndrop, 1);
    repeat (4) mstep(4'hF, 1, 1);
    chk("t4_count", acc_q.size(), 2);
    for (int i = 0; i < 2; i++) begin
      if (i < acc_q.size()) begin
        chk("t4_key", acc_q[i].k, 2);
        chk("t4_type", acc_q[i].t, 0);
      end
    end
    chk("t4_drop_total", ndrop, 1);

    // Reset while key0 is held and an event sits on the port.
    repeat (2) mstep(4'hD, 1, 0);
    repeat (2) mstep(4'hF, 1, 0);
    chk("t5_pre_valid", ev.evt_valid, 1);
    repeat (7) mstep(4'hE, 1, 0);
    acc_q.delete();
    do_reset();
    repeat (2) mstep(4'hE, 1, 1);
    repeat (6) mstep(4'hF, 1, 1);
    chk("t5_no_event", acc_q.size(), 0);

    // key3 held across en=0 past the LONG threshold.
    acc_q.delete();
    repeat (3) mstep(4'h7, 1, 1);
    repeat (15) mstep(4'h7, 0, 1);
    repeat (3) mstep(4'h7, 1, 1);
    repeat (4) mstep(4'hF, 1, 1);
    chk("t6_no_event", acc_q.size(), 0);
    repeat (3) mstep(4'h7, 1, 1);
    repeat (4) mstep(4'hF, 1, 1);
    chk("t6_count", acc_q.size(), 1);
    if (acc_q.size() > 0) begin
      chk("t6_key", acc_q[0].k, 3);
      chk("t6_type", acc_q[0].t, 0);
    end

    // Random traffic against the model.
    ks_r = '1;
    en_r = 1'b1;
    for (int n = 0; n < 4000; n++) begin
      for (int k = 0; k < NK; k++)
        if ($urandom_range(7) == 0) ks_r[k] = ~ks_r[k];
      if ($urandom_range(149) == 0) en_r = ~en_r;
      if (!en_r && $urandom_range(9) == 0) en_r = 1'b1;
      mstep(ks_r, en_r, ($urandom_range(3) != 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
